// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: register offsets, status bit positions and receiver FSM states.
// The transmitter imports this package too, so keep offsets stable.
package uart_defs;

    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAMING   = 3;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
// A push into a full FIFO only lands when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge i_clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM, RX FIFO and a one-request-one-response bus port.
// Sticky overrun/framing flags are cleared by writing ones to their STATUS bits.
module uart_receiver
    import uart_defs::*;
#(
    parameter int FREQUENCY  = 50000000,
    parameter int BAUDRATE   = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    input  logic        UART_RX
);
    localparam int BIT_CYCLES = FREQUENCY / BAUDRATE;
    localparam int HALF       = BIT_CYCLES / 2;
    localparam int CW         = $clog2(BIT_CYCLES);
    localparam int FW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] LAST    = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    logic            rx_meta;
    logic            rx_s;
    rx_state_t       state, state_next;
    logic [CW-1:0]   counter, counter_next;
    logic [2:0]      bit_idx, bit_idx_next;
    logic [7:0]      shift, shift_next;
    logic            push;
    logic            framing_set;

    logic            served;
    logic            overrun;
    logic            framing;
    logic            access;
    logic [1:0]      reg_sel;
    logic            pop;
    logic            overrun_set;
    logic            status_wr;
    logic [31:0]     rdata_next;
    logic [7:0]      fifo_rdata;
    logic            empty;
    logic            full;
    logic [FW-1:0]   fifo_count;
    logic            unused;

    assign unused = ^{i_address[31:4], i_address[1:0], i_wdata[31:4], i_wdata[1:0]};

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            state   <= RX_IDLE;
            counter <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            rx_meta <= UART_RX;
            rx_s    <= rx_meta;
            state   <= state_next;
            counter <= counter_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
        end
    end

    // Stop is judged mid-bit and we go idle right away, so a back-to-back start edge is not missed.
    always_comb begin
        state_next   = state;
        counter_next = counter + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        push         = 1'b0;
        framing_set  = 1'b0;
        case (state)
            RX_IDLE: begin
                counter_next = '0;
                if (!rx_s) begin
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (counter == HALF_M1) begin
                    counter_next = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (counter == LAST) begin
                    counter_next = '0;
                    shift_next   = {rx_s, shift[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (counter == LAST) begin
                    counter_next = '0;
                    push         = rx_s;
                    framing_set  = !rx_s;
                    state_next   = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .push    (push),
        .wdata   (shift),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .empty   (empty),
        .full    (full),
        .count   (fifo_count)
    );

    assign access      = i_enable && !served;
    assign reg_sel     = i_address[3:2];
    assign pop         = access && !i_rw && (reg_sel == UART_REG_DATA) && !empty;
    assign overrun_set = push && full && !pop;
    assign status_wr   = access && i_rw && (reg_sel == UART_REG_STATUS);

    always_comb begin
        rdata_next = '0;
        if (reg_sel == UART_REG_DATA && !empty) begin
            rdata_next = {24'h0, fifo_rdata};
        end else if (reg_sel == UART_REG_STATUS) begin
            rdata_next[STAT_NOT_EMPTY]                 = !empty;
            rdata_next[STAT_FULL]                      = full;
            rdata_next[STAT_OVERRUN]                   = overrun;
            rdata_next[STAT_FRAMING]                   = framing;
            rdata_next[STAT_COUNT_LSB +: 8]            = 8'(fifo_count);
        end
    end

    // A new error in the same cycle as a clearing write must survive, hence the OR after the clear.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_rdata <= '0;
            o_ready <= 1'b0;
            served  <= 1'b0;
            overrun <= 1'b0;
            framing <= 1'b0;
        end else begin
            if (access) begin
                served  <= 1'b1;
                o_ready <= 1'b1;
                o_rdata <= i_rw ? 32'h0 : rdata_next;
            end else if (!i_enable) begin
                served  <= 1'b0;
                o_ready <= 1'b0;
            end
            overrun <= (overrun && !(status_wr && i_wdata[STAT_OVERRUN])) || overrun_set;
            framing <= (framing && !(status_wr && i_wdata[STAT_FRAMING])) || framing_set;
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames against a queue-based model.
// Model tracks received bytes and sticky flags only from line-level 8N1 rules.
module tb_uart_receiver;

    localparam int DEPTH = 16;
    localparam int BITC  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        rw;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        rx;

    int errors = 0;
    int checks = 0;

    logic [7:0] q[$];
    bit         ovr;
    bit         frm;
    logic [31:0] rd;
    logic [7:0]  exp_byte;

    always #5 clk = ~clk;

    uart_receiver #(.FREQUENCY(1600), .BAUDRATE(100), .FIFO_DEPTH(DEPTH)) dut (
        .i_clock   (clk),
        .i_reset   (reset),
        .i_enable  (enable),
        .i_rw      (rw),
        .i_address (address),
        .i_wdata   (wdata),
        .o_rdata   (rdata),
        .o_ready   (ready),
        .UART_RX   (rx)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_status();
        return {16'h0, 8'(q.size()), 4'h0, frm, ovr, q.size() == DEPTH, q.size() != 0};
    endfunction

    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) frm = 1'b1;
        else if (q.size() == DEPTH) ovr = 1'b1;
        else q.push_back(b);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        @(negedge clk) rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BITC) @(negedge clk);
        end
        rx = stop_ok;
        repeat (BITC) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        model_frame(b, stop_ok);
    endtask

    task automatic bus_access(input logic wr, input logic [1:0] sel, input logic [31:0] wd,
                              output logic [31:0] rdv);
        int n;
        @(negedge clk);
        enable  = 1'b1;
        rw      = wr;
        address = {28'h0, sel, 2'b00};
        wdata   = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 10);
        if (!ready) check_output("ready_timeout", {31'h0, ready}, 32'h1);
        rdv    = rdata;
        enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_status(input string tag);
        logic [31:0] v;
        bus_access(1'b0, 2'd1, 32'h0, v);
        check_output(tag, v, model_status());
    endtask

    task automatic read_data(input string tag);
        logic [31:0] v;
        logic [31:0] e;
        e = (q.size() != 0) ? {24'h0, q.pop_front()} : 32'h0;
        bus_access(1'b0, 2'd0, 32'h0, v);
        check_output(tag, v, e);
    endtask

    task automatic write_status(input logic [31:0] wd);
        logic [31:0] v;
        bus_access(1'b1, 2'd1, wd, v);
        if (wd[2]) ovr = 1'b0;
        if (wd[3]) frm = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; rw = 1'b0; address = '0; wdata = '0; rx = 1'b1;
        q.delete(); ovr = 1'b0; frm = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_output("reset_ready", {31'h0, ready}, 32'h0);
        check_output("reset_rdata", rdata, 32'h0);
        read_status("reset_status");
        bus_access(1'b0, 2'd2, 32'h0, rd);
        check_output("reg2_read", rd, 32'h0);

        send_frame(8'hA5, 1'b1);
        check_output("a5_status_const", model_status(), 32'h0000_0101);
        read_status("a5_status");
        read_data("a5_data");
        read_status("a5_status_after");
        read_data("empty_data");

        @(negedge clk) rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        read_status("glitch_status");

        send_frame(8'h3C, 1'b0);
        read_status("framing_status");
        write_status(32'h8);
        read_status("framing_cleared");

        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        read_status("overrun_status");
        for (int i = 0; i < 16; i++) read_data($sformatf("ovr_data_%0d", i));
        read_status("overrun_drained");
        write_status(32'h4);
        read_status("overrun_cleared");

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        @(negedge clk);
        enable = 1'b1; rw = 1'b0; address = 32'h0; wdata = '0;
        exp_byte = q.pop_front();
        #1 check_output("hold_ready_c1", {31'h0, ready}, 32'h0);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            check_output($sformatf("hold_ready_c%0d", k), {31'h0, ready}, 32'h1);
            check_output($sformatf("hold_rdata_c%0d", k), rdata, {24'h0, exp_byte});
        end
        enable = 1'b0;
        @(negedge clk);
        check_output("hold_ready_drop", {31'h0, ready}, 32'h0);
        read_data("hold_next");
        read_status("hold_status");

        for (int it = 0; it < 10; it++) begin
            send_frame(8'($urandom), $urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: read_data($sformatf("rand_data_%0d", it));
                1: write_status(32'($urandom_range(0, 15)) << 0);
                default: ;
            endcase
            read_status($sformatf("rand_status_%0d", it));
        end
        while (q.size() != 0) read_data("rand_drain");
        write_status(32'hC);
        read_status("rand_final_status");

        @(negedge clk) rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (BITC) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BITC / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete(); ovr = 1'b0; frm = 1'b0;
        check_output("midreset_ready", {31'h0, ready}, 32'h0);
        check_output("midreset_rdata", rdata, 32'h0);
        repeat (200) @(negedge clk);
        read_status("midreset_status");
        send_frame(8'h5A, 1'b1);
        read_status("post_reset_status");
        read_data("post_reset_data");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
